// File: rtl/regfile_param.sv
// Parameterised register file with a self-clearing start-up sequence, two
// combinational read ports and one acknowledged write port.
// Optional same-cycle write-to-read forwarding: define REGFILE_BYPASS_EN.
module regfile_param #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] rd,
  input  logic [DATA_W-1:0] di,
  input  logic [ADDR_W-1:0] ra,
  input  logic [ADDR_W-1:0] rb,
  output logic [DATA_W-1:0] qa,
  output logic [DATA_W-1:0] qb,
  output logic              ready,
  output logic              wack,
  output logic              dbg_state_o,
  output logic [ADDR_W-1:0] dbg_clr_addr_o
);

  // Handshake: we is a request sampled at the rising edge; it is accepted
  // only while ready = 1, and wack is high for exactly the following cycle.

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  typedef enum logic {S_CLEAR, S_RUN} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
  logic              wack_q, wack_d;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic              wr_stored;

  // A write to address 0 is acknowledged but dropped when it is hardwired.
  assign wr_stored = !((ZERO_REG != 0) && (rd == '0));

  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    wack_d     = 1'b0;
    mem_we     = 1'b0;
    mem_waddr  = clr_addr_q;
    mem_wdata  = '0;
    if (rst) begin
      state_d    = S_CLEAR;
      clr_addr_d = '0;
    end else begin
      case (state_q)
        S_CLEAR: begin
          mem_we     = 1'b1;
          clr_addr_d = clr_addr_q + ADDR_W'(1);
          if (clr_addr_q == LAST_ADDR) state_d = S_RUN;
        end
        S_RUN: begin
          if (we) begin
            wack_d    = 1'b1;
            mem_we    = wr_stored;
            mem_waddr = rd;
            mem_wdata = di;
          end
        end
        default: state_d = S_CLEAR;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_CLEAR;
      clr_addr_q <= '0;
      wack_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
      wack_q     <= wack_d;
    end
  end

  // Storage has no reset of its own; the CLEAR sweep zeroes it.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  always_comb begin
    qa = '0;
    qb = '0;
    if (state_q == S_RUN) begin
      if (!((ZERO_REG != 0) && (ra == '0))) qa = mem_q[ra];
      if (!((ZERO_REG != 0) && (rb == '0))) qb = mem_q[rb];
`ifdef REGFILE_BYPASS_EN
      if (we && wr_stored && (ra == rd)) qa = di;
      if (we && wr_stored && (rb == rd)) qb = di;
`endif
    end
  end

  assign ready          = (state_q == S_RUN);
  assign wack           = wack_q;
  assign dbg_state_o    = (state_q == S_RUN);
  assign dbg_clr_addr_o = clr_addr_q;

endmodule
